scan_sel_gen: RTL and testbench

SCAN_SEL_GEN -- requirements
Module: scan_sel_gen

---
 rtl/scan_pkg.sv | 13 +
 rtl/rr_next4.sv | 32 +++
 rtl/scan_sel_gen.sv | 128 ++++++++++++
 tb/tb_scan_sel_gen.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/scan_pkg.sv
// Shared types and sizing for the scan select generator.
package scan_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DWELL = 2'd2
  } scan_state_e;

endpackage

// File: rtl/rr_next4.sv
// Circular next-channel search over a 4-bit enable mask, starting after i_cur.
module rr_next4
  import scan_pkg::*;
(
  input  logic [SEL_W-1:0]  i_cur,
  input  logic [NUM_CH-1:0] i_mask,
  output logic [SEL_W-1:0]  o_next,
  output logic              o_wrap,
  output logic              o_none
);

  logic [SEL_W-1:0] w_idx;
  logic             w_found;

  // Candidates are visited as i_cur+1 .. i_cur+3, then i_cur itself.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    o_next  = i_cur;
    w_found = 1'b0;
    w_idx   = i_cur;
    for (int k = 1; k <= NUM_CH; k++) begin
      w_idx = i_cur + SEL_W'(k);
      if (!w_found && i_mask[w_idx]) begin
        o_next  = w_idx;
        w_found = 1'b1;
      end
    end
    o_none = !w_found;
    o_wrap = w_found && (o_next <= i_cur);
  end

endmodule

// File: rtl/scan_sel_gen.sv
// Round-robin channel scanner: blanking gap, then a dwell window per enabled channel.
module scan_sel_gen
  import scan_pkg::*;
#(
  parameter int DWELL_W      = 16,
  parameter int BLANK_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [NUM_CH-1:0]  ch_mask,
  output logic [SEL_W-1:0]   sel,
  output logic               sel_valid,
  output logic               blank,
  output logic               frame_done
);

  localparam logic [3:0]         BLANK_LOAD = 4'(BLANK_CYCLES - 1);
  localparam logic [DWELL_W-1:0] DWELL_ONE  = DWELL_W'(1);

  scan_state_e        r_state, w_state_nxt;
  logic [SEL_W-1:0]   r_sel, w_sel_nxt;
  logic [3:0]         r_blank_cnt, w_blank_cnt_nxt;
  logic [DWELL_W-1:0] r_dwell_cnt, w_dwell_cnt_nxt;
  logic               r_sel_valid, w_sel_valid_nxt;
  logic               r_blank, w_blank_nxt;
  logic               r_frame_done, w_frame_done_nxt;

  logic [SEL_W-1:0]   w_search_from;
  logic [SEL_W-1:0]   w_next_ch;
  logic               w_wrap;
  logic               w_none;

  // Searching from the top index makes the first hit the lowest enabled channel.
  assign w_search_from = (r_state == IDLE) ? SEL_W'(NUM_CH - 1) : r_sel;

  rr_next4 u_rr_next4 (
    .i_cur  (w_search_from),
    .i_mask (ch_mask),
    .o_next (w_next_ch),
    .o_wrap (w_wrap),
    .o_none (w_none)
  );

  always_comb begin
    w_state_nxt      = r_state;
    w_sel_nxt        = r_sel;
    w_blank_cnt_nxt  = r_blank_cnt;
    w_dwell_cnt_nxt  = r_dwell_cnt;
    w_sel_valid_nxt  = 1'b0;
    w_blank_nxt      = 1'b0;
    w_frame_done_nxt = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (en && !w_none) begin
          w_state_nxt     = BLANK;
          w_sel_nxt       = w_next_ch;
          w_blank_cnt_nxt = BLANK_LOAD;
          w_blank_nxt     = 1'b1;
        end
      end
      BLANK: begin
        if (!en) begin
          w_state_nxt     = IDLE;
          w_blank_cnt_nxt = '0;
        end else if (r_blank_cnt == '0) begin
          w_state_nxt     = DWELL;
          w_dwell_cnt_nxt = (dwell == '0) ? '0 : dwell - DWELL_ONE;
          w_sel_valid_nxt = 1'b1;
        end else begin
          w_blank_cnt_nxt = r_blank_cnt - 4'd1;
          w_blank_nxt     = 1'b1;
        end
      end
      DWELL: begin
        if (!en) begin
          w_state_nxt     = IDLE;
          w_dwell_cnt_nxt = '0;
        end else if (r_dwell_cnt == '0) begin
          // Channel switch: the only point where ch_mask is consulted mid-scan.
          w_dwell_cnt_nxt = '0;
          if (w_none) begin
            w_state_nxt = IDLE;
          end else begin
            w_state_nxt      = BLANK;
            w_sel_nxt        = w_next_ch;
            w_blank_cnt_nxt  = BLANK_LOAD;
            w_blank_nxt      = 1'b1;
            w_frame_done_nxt = w_wrap;
          end
        end else begin
          w_dwell_cnt_nxt = r_dwell_cnt - DWELL_ONE;
          w_sel_valid_nxt = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_sel        <= '0;
      r_blank_cnt  <= '0;
      r_dwell_cnt  <= '0;
      r_sel_valid  <= 1'b0;
      r_blank      <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_sel        <= w_sel_nxt;
      r_blank_cnt  <= w_blank_cnt_nxt;
      r_dwell_cnt  <= w_dwell_cnt_nxt;
      r_sel_valid  <= w_sel_valid_nxt;
      r_blank      <= w_blank_nxt;
      r_frame_done <= w_frame_done_nxt;
    end
  end

  assign sel        = r_sel;
  assign sel_valid  = r_sel_valid;
  assign blank      = r_blank;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_scan_sel_gen.sv
// Scoreboard bench: a visit-level scan model queues expected active cycles, a monitor pops them.
module tb_scan_sel_gen;

  localparam int BC = 2;
  localparam int DW = 16;

  logic          clk;
  logic          rst_n;
  logic          en;
  logic [DW-1:0] dwell;
  logic [3:0]    ch_mask;
  logic [1:0]    sel;
  logic          sel_valid;
  logic          blank;
  logic          frame_done;

  int errors = 0;
  int checks = 0;

  // Expected active cycle: {sel, sel_valid, blank, frame_done}
  logic [4:0] exp_q[$];
  logic [1:0] exp_sel;

  scan_sel_gen #(.DWELL_W(DW), .BLANK_CYCLES(BC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .dwell      (dwell),
    .ch_mask    (ch_mask),
    .sel        (sel),
    .sel_valid  (sel_valid),
    .blank      (blank),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] lowest(input logic [3:0] m);
    logic [1:0] r = 2'd0;
    for (int i = 3; i >= 0; i--) if (m[i]) r = 2'(i);
    return r;
  endfunction

  function automatic logic [1:0] next_after(input logic [1:0] ch, input logic [3:0] m);
    logic [1:0] r = ch;
    for (int i = 4; i >= 1; i--) if (m[(int'(ch) + i) % 4]) r = 2'((int'(ch) + i) % 4);
    return r;
  endfunction

  // Visit-level model: mask m0 until cycle k, m1 from cycle k on; en held for T cycles.
  task automatic model(input logic [3:0] m0, input logic [3:0] m1, input int k,
                       input logic [DW-1:0] dw, input int t);
    int         c = 0;
    int         dlen;
    bit         first = 1'b1;
    logic [1:0] ch;
    logic [1:0] prev = 2'd0;
    logic [3:0] m;
    dlen = (dw == 0) ? 1 : int'(dw);
    if (m0 == 4'd0) return;
    ch = lowest(m0);
    while (c < t) begin
      for (int b = 0; b < BC; b++) begin
        if (c < t) begin
          c++;
          exp_q.push_back({ch, 1'b0, 1'b1, (b == 0) && !first && (ch <= prev)});
          exp_sel = ch;
        end
      end
      for (int d = 0; d < dlen; d++) begin
        if (c < t) begin
          c++;
          exp_q.push_back({ch, 1'b1, 1'b0, 1'b0});
        end
      end
      if (c >= t) break;
      m = (c >= k) ? m1 : m0;
      if (m == 4'd0) break;
      prev  = ch;
      ch    = next_after(ch, m);
      first = 1'b0;
    end
  endtask

  // Monitor: every cycle the DUT shows activity must match the next queued entry.
  always @(negedge clk) begin
    if (rst_n && (sel_valid || blank || frame_done)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_activity", {27'd0, sel, sel_valid, blank, frame_done}, 32'd0);
      end else begin
        check("active_cycle", {27'd0, sel, sel_valid, blank, frame_done}, {27'd0, exp_q.pop_front()});
      end
    end
  end

  // Starts and ends on a negedge with the DUT in IDLE.
  task automatic run_seg(input logic [3:0] m0, input logic [3:0] m1, input int k,
                         input logic [DW-1:0] dw, input int t);
    model(m0, m1, k, dw, t);
    en      = 1'b1;
    ch_mask = m0;
    dwell   = dw;
    for (int c = 1; c <= t; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (c == k) ch_mask = m1;
      if (c == t) en = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    check("idle_outputs", {29'd0, sel_valid, blank, frame_done}, 32'd0);
    check("idle_sel_hold", {30'd0, sel}, {30'd0, exp_sel});
    check("queue_drained", exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    rst_n   = 1'b0;
    en      = 1'b0;
    dwell   = '0;
    ch_mask = 4'd0;
    exp_sel = 2'd0;
    #12;
    check("reset_outputs", {27'd0, sel, sel_valid, blank, frame_done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_seg(4'b1111, 4'b1111, 1, 16'd3, 25);  // 0,1,2,3,0 with wrap pulse
    run_seg(4'b1010, 4'b1010, 1, 16'd0, 12);  // 1,3 alternating, dwell 0 -> 1
    run_seg(4'b0100, 4'b0100, 1, 16'd2, 16);  // single channel, 4-cycle period
    run_seg(4'b1111, 4'b0001, 9, 16'd3, 20);  // mask shrinks mid-dwell of channel 1
    run_seg(4'b1111, 4'b1111, 1, 16'd3, 14);  // en dropped mid-dwell of channel 2
    run_seg(4'b0000, 4'b0000, 1, 16'd3, 10);  // nothing enabled: stays idle
    run_seg(4'b1100, 4'b0000, 6, 16'd1, 20);  // mask cleared -> back to IDLE

    for (int i = 0; i < 20; i++) begin
      int t;
      t = int'($urandom_range(40, 1));
      run_seg(4'($urandom), 4'($urandom), int'($urandom_range(t, 1)),
              DW'($urandom_range(4, 0)), t);
    end

    // Asynchronous reset during the first blanking cycle.
    model(4'b1111, 4'b1111, 1, 16'd3, 1);
    en      = 1'b1;
    ch_mask = 4'b1111;
    dwell   = 16'd3;
    @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {27'd0, sel, sel_valid, blank, frame_done}, 32'd0);
    check("async_reset_queue", exp_q.size(), 32'd0);
    en      = 1'b0;
    exp_sel = 2'd0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_seg(4'b0110, 4'b0110, 1, 16'd1, 10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
